sc_return_stack: RTL and testbench

Hardware return-address stack for the processor datapath. It stores the incremented program-counter values produced by the address-increment register on CALL and returns them on RET, so it is the reader end of that address stream. It sits between the PC-increment stage (push data source) and the PC input multiplexer (pop data consumer). The stack is LIFO with registered state, full/empty status and sticky error flags.

---
 rtl/sc_return_stack.sv | 89 ++++++++
 tb/tb_sc_return_stack.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_return_stack.sv
// Return-address stack: LIFO of PC+1 values pushed on CALL and popped on RET.
// Provides full/empty/count status and sticky overflow/underflow flags.
module sc_return_stack #(
    parameter int DATAWIDTH_BUS_RAS = 11,
    parameter int DEPTH_RAS         = 8,
    parameter int PTRWIDTH_RAS      = 3
) (
    input  logic                         SC_RAS_CLOCK_50,
    input  logic                         SC_RAS_RESET_InHigh,
    input  logic                         RAS_PUSH_InHigh,
    input  logic                         RAS_POP_InHigh,
    input  logic                         RAS_CLRERR_InHigh,
    input  logic [DATAWIDTH_BUS_RAS-1:0] RAS_DATA_INPUT,
    output logic [DATAWIDTH_BUS_RAS-1:0] RAS_DATA_OUTPUT,
    output logic [PTRWIDTH_RAS:0]        RAS_COUNT,
    output logic                         RAS_EMPTY_OutHigh,
    output logic                         RAS_FULL_OutHigh,
    output logic                         RAS_OVERFLOW_OutHigh,
    output logic                         RAS_UNDERFLOW_OutHigh
);

    localparam logic [PTRWIDTH_RAS:0]   LP_DEPTH   = (PTRWIDTH_RAS+1)'(DEPTH_RAS);
    localparam logic [PTRWIDTH_RAS:0]   LP_ONE_CNT = (PTRWIDTH_RAS+1)'(1);
    localparam logic [PTRWIDTH_RAS-1:0] LP_ONE_IDX = PTRWIDTH_RAS'(1);

    logic [DATAWIDTH_BUS_RAS-1:0] r_mem [DEPTH_RAS];
    logic [PTRWIDTH_RAS:0]        r_cnt;
    logic                         r_ovf;
    logic                         r_unf;

    logic                    w_empty;
    logic                    w_full;
    logic [PTRWIDTH_RAS-1:0] w_wr_idx;
    logic [PTRWIDTH_RAS-1:0] w_top_idx;
    logic                    w_do_push;
    logic                    w_do_pop;
    logic                    w_do_repl;
    logic                    w_ovf_evt;
    logic                    w_unf_evt;
    logic                    w_mem_we;
    logic [PTRWIDTH_RAS-1:0] w_mem_idx;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == LP_DEPTH);
    // When full the low bits wrap to 0, so top index still lands on DEPTH-1.
    assign w_wr_idx  = r_cnt[PTRWIDTH_RAS-1:0];
    assign w_top_idx = r_cnt[PTRWIDTH_RAS-1:0] - LP_ONE_IDX;

    assign w_do_push = RAS_PUSH_InHigh & ~RAS_POP_InHigh & ~w_full;
    assign w_do_pop  = RAS_POP_InHigh & ~RAS_PUSH_InHigh & ~w_empty;
    assign w_do_repl = RAS_PUSH_InHigh & RAS_POP_InHigh & ~w_empty;
    assign w_ovf_evt = RAS_PUSH_InHigh & ~RAS_POP_InHigh & w_full;
    assign w_unf_evt = RAS_POP_InHigh & w_empty;

    assign w_mem_we  = w_do_push | w_do_repl;
    assign w_mem_idx = w_do_push ? w_wr_idx : w_top_idx;

    // Array is not reset; its contents are only visible through a nonzero count.
    always_ff @(posedge SC_RAS_CLOCK_50) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= RAS_DATA_INPUT;
        end
    end

    always_ff @(posedge SC_RAS_CLOCK_50 or posedge SC_RAS_RESET_InHigh) begin
        if (SC_RAS_RESET_InHigh) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_cnt <= r_cnt + LP_ONE_CNT;
            end else if (w_do_pop) begin
                r_cnt <= r_cnt - LP_ONE_CNT;
            end
            // An error event on the same edge as a clear leaves the flag set.
            r_ovf <= (r_ovf & ~RAS_CLRERR_InHigh) | w_ovf_evt;
            r_unf <= (r_unf & ~RAS_CLRERR_InHigh) | w_unf_evt;
        end
    end

    assign RAS_DATA_OUTPUT       = w_empty ? '0 : r_mem[w_top_idx];
    assign RAS_COUNT             = r_cnt;
    assign RAS_EMPTY_OutHigh     = w_empty;
    assign RAS_FULL_OutHigh      = w_full;
    assign RAS_OVERFLOW_OutHigh  = r_ovf;
    assign RAS_UNDERFLOW_OutHigh = r_unf;

endmodule

// File: tb/tb_sc_return_stack.sv
// Bench for sc_return_stack: directed scenarios plus random CALL/RET traffic,
// checked against a queue-based stack model through an expected-response queue.
module tb_sc_return_stack;

  localparam int DW    = 11;
  localparam int DEPTH = 8;
  localparam int PW    = 3;
  localparam int EW    = DW + PW + 1 + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic [PW:0]   count;
  logic          empty, full, ovf, unf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] model_q[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  sc_return_stack #(
    .DATAWIDTH_BUS_RAS(DW),
    .DEPTH_RAS(DEPTH),
    .PTRWIDTH_RAS(PW)
  ) dut (
    .SC_RAS_CLOCK_50(clk),
    .SC_RAS_RESET_InHigh(rst),
    .RAS_PUSH_InHigh(push),
    .RAS_POP_InHigh(pop),
    .RAS_CLRERR_InHigh(clr),
    .RAS_DATA_INPUT(din),
    .RAS_DATA_OUTPUT(dout),
    .RAS_COUNT(count),
    .RAS_EMPTY_OutHigh(empty),
    .RAS_FULL_OutHigh(full),
    .RAS_OVERFLOW_OutHigh(ovf),
    .RAS_UNDERFLOW_OutHigh(unf)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: a plain queue used as a stack
  function automatic logic [EW-1:0] model_expect();
    logic [DW-1:0] d;
    int n;
    n = model_q.size();
    d = (n > 0) ? model_q[n-1] : '0;
    return {d, 4'(n), (n == 0), (n == DEPTH), m_ovf, m_unf};
  endfunction

  task automatic model_step(input bit p, input bit q, input bit c, input logic [DW-1:0] d);
    bit oe, ue;
    int n;
    oe = 0;
    ue = 0;
    n = model_q.size();
    if (p && !q) begin
      if (n == DEPTH) oe = 1;
      else model_q.push_back(d);
    end else if (q && !p) begin
      if (n == 0) ue = 1;
      else void'(model_q.pop_back());
    end else if (p && q) begin
      if (n == 0) ue = 1;
      else model_q[n-1] = d;
    end
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (oe) m_ovf = 1'b1;
    if (ue) m_unf = 1'b1;
  endtask

  // scoreboard comparisons
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic check_all(input string tag, input logic [EW-1:0] e);
    check({tag, ".data"},  32'(dout),  32'(e[EW-1 -: DW]));
    check({tag, ".count"}, 32'(count), 32'(e[7:4]));
    check({tag, ".empty"}, 32'(empty), 32'(e[3]));
    check({tag, ".full"},  32'(full),  32'(e[2]));
    check({tag, ".ovf"},   32'(ovf),   32'(e[1]));
    check({tag, ".unf"},   32'(unf),   32'(e[0]));
  endtask

  // directed absolute expectation, independent of the model
  task automatic check_now(input string tag, input logic [DW-1:0] d, input int c,
                           input bit e, input bit f, input bit o, input bit u);
    check_all(tag, {d, 4'(c), e, f, o, u});
  endtask

  // monitor: pops one expected response per cycle
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_all("mon", e);
    end
  end

  // driver
  task automatic do_op(input bit p, input bit q, input bit c, input logic [DW-1:0] d);
    push = p;
    pop  = q;
    clr  = c;
    din  = d;
    @(posedge clk);
    model_step(p, q, c, d);
    exp_q.push_back(model_expect());
    #1;
    push = 1'b0;
    pop  = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic pop_all();
    while (model_q.size() > 0) do_op(0, 1, 0, '0);
  endtask

  initial begin
    #12;
    check_now("reset", '0, 0, 1, 0, 0, 0);
    rst = 1'b0;

    // basic push/pop ordering
    do_op(1, 0, 0, 11'h005);
    do_op(1, 0, 0, 11'h00A);
    do_op(1, 0, 0, 11'h7FF);
    check_now("tp1.push3", 11'h7FF, 3, 0, 0, 0, 0);
    do_op(0, 1, 0, '0);
    check_now("tp1.pop1", 11'h00A, 2, 0, 0, 0, 0);
    do_op(0, 1, 0, '0);
    check_now("tp1.pop2", 11'h005, 1, 0, 0, 0, 0);
    do_op(0, 1, 0, '0);
    check_now("tp1.pop3", '0, 0, 1, 0, 0, 0);

    // fill, overflow, no overwrite
    for (int i = 1; i <= 8; i++) do_op(1, 0, 0, 11'(i));
    check_now("tp2.full", 11'h008, 8, 0, 1, 0, 0);
    do_op(1, 0, 0, 11'h009);
    check_now("tp2.ovf", 11'h008, 8, 0, 1, 1, 0);
    do_op(0, 1, 0, '0);
    check_now("tp2.pop", 11'h007, 7, 0, 0, 1, 0);
    do_op(0, 0, 1, '0);
    pop_all();

    // underflow is sticky until cleared
    do_op(0, 1, 0, '0);
    check_now("tp3.unf", '0, 0, 1, 0, 0, 1);
    do_op(1, 0, 0, 11'h123);
    check_now("tp3.push", 11'h123, 1, 0, 0, 0, 1);
    do_op(0, 0, 1, '0);
    check_now("tp3.clr", 11'h123, 1, 0, 0, 0, 0);
    pop_all();

    // replace-top and push+pop on empty
    do_op(1, 0, 0, 11'h010);
    do_op(1, 0, 0, 11'h020);
    do_op(1, 1, 0, 11'h030);
    check_now("tp4.repl", 11'h030, 2, 0, 0, 0, 0);
    do_op(0, 1, 0, '0);
    check_now("tp4.pop", 11'h010, 1, 0, 0, 0, 0);
    do_op(0, 1, 0, '0);
    do_op(1, 1, 0, 11'h040);
    check_now("tp4.empty_pp", '0, 0, 1, 0, 0, 1);
    do_op(0, 0, 1, '0);

    // set wins over clear; replace while full
    for (int i = 0; i < 8; i++) do_op(1, 0, 0, 11'(12'h100 + i));
    do_op(1, 0, 1, 11'h3AA);
    check_now("tp5.set_wins", 11'h107, 8, 0, 1, 1, 0);
    do_op(1, 1, 0, 11'h2BB);
    check_now("tp5.repl_full", 11'h2BB, 8, 0, 1, 1, 0);
    do_op(0, 0, 1, '0);
    pop_all();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      bit p, q, c;
      r = $urandom_range(0, 15);
      p = (r < 7) || (r == 14);
      q = (r >= 6 && r < 13) || (r == 14);
      c = ($urandom_range(0, 15) == 0);
      do_op(p, q, c, 11'($urandom_range(0, 2047)));
    end

    // asynchronous reset between edges
    do_op(1, 0, 0, 11'h055);
    do_op(1, 0, 0, 11'h055);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_now("tp6.async_rst", '0, 0, 1, 0, 0, 0);
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    exp_q.delete();
    #1;
    rst = 1'b0;
    do_op(0, 1, 0, '0);
    check_now("tp6.unf", '0, 0, 1, 0, 0, 1);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
